// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   *_DEF      : default parameter values for SIZE_DATA / OVER_SAMPLE /
//                SYNC_STAGES
//   maj3()     : 2-of-3 majority vote, used when UART_RX_MAJORITY_EN is set
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int unsigned SIZE_DATA_DEF   = 8;
    localparam int unsigned OVER_SAMPLE_DEF = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// ----------------------------------------------------------------------------
// uart_sync_bit
// Single-bit synchronizer: a chain of SYNC_STAGES flops that all reset to 1,
// so an idle-high serial line never shows a false low edge out of reset.
//   i_clk    : destination clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input
//   o_sync   : synchronized copy (last stage)
// ----------------------------------------------------------------------------
module uart_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking, so each stage takes the previous stage's
            // old value and the chain really is SYNC_STAGES flops deep.
            sync_q[0] <= i_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// ----------------------------------------------------------------------------
// uart_rx_oversample
// UART byte receiver with OVER_SAMPLE ticks per bit (tick = i_stick).
// Frame: start(0), SIZE_DATA data bits LSB first, stop(1).
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset
//   i_stick      : oversample tick, one i_clk wide
//   i_rx_en      : receiver enable; low forces IDLE and drops a partial frame
//   i_rx_data    : asynchronous serial line, idles high
//   o_rx_byte    : last good byte, held until the next good frame
//   o_rx_valid   : one-cycle pulse, o_rx_byte is new
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_busy       : FSM is not in IDLE
// Build option: define UART_RX_MAJORITY_EN to decide each sample by a 2-of-3
// vote over the decision tick and the two ticks before it.
// OVER_SAMPLE must be even and >= 8; SIZE_DATA must be >= 2.
// ----------------------------------------------------------------------------
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA   = SIZE_DATA_DEF,
    parameter int unsigned OVER_SAMPLE = OVER_SAMPLE_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx_en,
    input  logic                 i_rx_data,
    output logic [SIZE_DATA-1:0] o_rx_byte,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = $clog2(OVER_SAMPLE);
    localparam int unsigned BIT_W = $clog2(SIZE_DATA + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVER_SAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_SAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE_DATA - 1);

    logic rx_s;
    logic sample;

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [BIT_W-1:0]       bit_q,   bit_d;
    logic [SIZE_DATA-1:0]   shift_q, shift_d;
    logic [SIZE_DATA-1:0]   byte_q,  byte_d;
    logic                   valid_q, valid_d;
    logic                   err_q,   err_d;

    uart_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_rx_data),
        .o_sync  (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous ticks are stored; with rx_s on the decision tick they form
    // the three-tick voting window.
    logic [1:0] hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= 2'b11;
        end else if (i_stick) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = maj3({hist_q, rx_s});
`else
    assign sample = rx_s;
`endif

    always_comb begin
        // NOTE: every variable gets its default before the case, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (!i_rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) state_d = START;
                end
                START: begin
                    if (i_stick) begin
                        if (cnt_q == CNT_MID) begin
                            // High at the start-bit centre means a glitch.
                            state_d = sample ? IDLE : DATA;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_stick) begin
                        if (cnt_q == CNT_LAST) begin
                            // LSB first: new bits enter at the top and move down.
                            shift_d = {sample, shift_q[SIZE_DATA-1:1]};
                            cnt_d   = '0;
                            bit_d   = bit_q + BIT_W'(1);
                            if (bit_q == BIT_LAST) state_d = STOP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_stick) begin
                        if (cnt_q == CNT_LAST) begin
                            if (sample) begin
                                byte_d  = shift_q;
                                valid_d = 1'b1;
                                state_d = IDLE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = WAIT_HIGH;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A stuck-low line must not be mistaken for a new start.
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
            bit_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_rx_byte   = byte_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_oversample
// Drives serial frames (tick every 2 clocks, 16 ticks per bit = 32 clocks per
// bit) and compares the received bytes and error pulses against a queue-based
// frame model built from the frames that were sent.
// ----------------------------------------------------------------------------
module tb_uart_rx_oversample;

    localparam int SIZE_DATA   = 8;
    localparam int OVER_SAMPLE = 16;
    localparam int BIT_CLKS    = 32;

    logic       i_clk     = 1'b0;
    logic       i_rst_n   = 1'b0;
    logic       i_stick   = 1'b0;
    logic       i_rx_en   = 1'b0;
    logic       i_rx_data = 1'b1;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         err_seen  = 0;
    int         both_seen = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_oversample #(
        .SIZE_DATA   (SIZE_DATA),
        .OVER_SAMPLE (OVER_SAMPLE),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_stick     (i_stick),
        .i_rx_en     (i_rx_en),
        .i_rx_data   (i_rx_data),
        .o_rx_byte   (o_rx_byte),
        .o_rx_valid  (o_rx_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Tick high for one rising edge out of every two.
    initial forever begin
        @(negedge i_clk);
        i_stick = ~i_stick;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_rx_valid) begin
                got_q.push_back(o_rx_byte);
                got_cyc.push_back(cyc);
            end
            if (o_frame_err) err_seen++;
            if (o_rx_valid && o_frame_err) both_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic hold_line(input logic v, input int clks);
        i_rx_data = v;
        repeat (clks) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < SIZE_DATA; i++) hold_line(b[i], BIT_CLKS);
        hold_line(stop, BIT_CLKS);
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        err_seen  = 0;
        both_seen = 0;
    endtask

    task automatic test_reset();
        i_rst_n   = 1'b0;
        i_rx_en   = 1'b0;
        i_rx_data = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_rx_byte !== 8'h00) begin
            failures++; $display("FAIL reset_byte: got %h expected 00", o_rx_byte);
        end
        checks++;
        if ({o_rx_valid, o_frame_err, o_busy} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b expected 000", {o_rx_valid, o_frame_err, o_busy});
        end
        i_rst_n = 1'b1;
        i_rx_en = 1'b1;
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: busy got %b expected 0", o_busy);
        end
    endtask

    task automatic test_single();
        int t0;
        logic [7:0] v;
        clear_mon();
        t0 = cyc;
        send_frame(8'h55, 1'b1);
        hold_line(1'b1, 40);
        checks++;
        if (got_q.size() !== 1 || err_seen !== 0) begin
            failures++; $display("FAIL single_count: got valid=%0d err=%0d expected valid=1 err=0", got_q.size(), err_seen);
        end
        v = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (v !== 8'h55) begin
            failures++; $display("FAIL single_byte: got %h expected 55", v);
        end
        // Stop-bit centre is 9.5 bits (304 clocks) after the start edge,
        // plus synchronizer and tick-phase delay.
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] - t0 < 300 || got_cyc[0] - t0 > 315) begin
            failures++;
            $display("FAIL single_latency: got %0d clocks expected 300..315",
                     (got_cyc.size() > 0) ? got_cyc[0] - t0 : -1);
        end
        last_good = 8'h55;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v0, v1;
        clear_mon();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        hold_line(1'b1, 40);
        v0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        v1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
        checks++;
        if (got_q.size() !== 2 || err_seen !== 0) begin
            failures++; $display("FAIL b2b_count: got valid=%0d err=%0d expected valid=2 err=0", got_q.size(), err_seen);
        end
        checks++;
        if ({v0, v1} !== 16'hA33C) begin
            failures++; $display("FAIL b2b_bytes: got %h %h expected a3 3c", v0, v1);
        end
        last_good = 8'h3C;
    endtask

    task automatic test_glitch();
        logic [7:0] v;
        clear_mon();
        hold_line(1'b0, 8);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++; $display("FAIL glitch_start: busy got %b expected 1", o_busy);
        end
        hold_line(1'b1, 16);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++; $display("FAIL glitch_reject: busy got %b expected 0", o_busy);
        end
        checks++;
        if (got_q.size() !== 0 || err_seen !== 0) begin
            failures++; $display("FAIL glitch_pulses: got valid=%0d err=%0d expected 0 0", got_q.size(), err_seen);
        end
        hold_line(1'b1, 16);
        send_frame(8'h7E, 1'b1);
        hold_line(1'b1, 40);
        v = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (got_q.size() !== 1 || v !== 8'h7E) begin
            failures++; $display("FAIL glitch_next: got count=%0d byte=%h expected 1 7e", got_q.size(), v);
        end
        last_good = 8'h7E;
    endtask

    task automatic test_frame_err();
        logic [7:0] v;
        clear_mon();
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < SIZE_DATA; i++) hold_line(1'b1, BIT_CLKS);
        hold_line(1'b0, 2 * 40);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++; $display("FAIL err_wait_high: busy got %b expected 1", o_busy);
        end
        checks++;
        if (err_seen !== 1 || got_q.size() !== 0) begin
            failures++; $display("FAIL err_pulse: got err=%0d valid=%0d expected err=1 valid=0", err_seen, got_q.size());
        end
        checks++;
        if (o_rx_byte !== last_good) begin
            failures++; $display("FAIL err_byte_held: got %h expected %h", o_rx_byte, last_good);
        end
        hold_line(1'b1, 8);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++; $display("FAIL err_release: busy got %b expected 0", o_busy);
        end
        hold_line(1'b1, 24);
        send_frame(8'h01, 1'b1);
        hold_line(1'b1, 40);
        v = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (got_q.size() !== 1 || v !== 8'h01 || err_seen !== 1) begin
            failures++; $display("FAIL err_next: got count=%0d byte=%h err=%0d expected 1 01 1", got_q.size(), v, err_seen);
        end
        last_good = 8'h01;
    endtask

    task automatic test_rx_en_drop();
        logic [7:0] b;
        logic [7:0] v;
        b = 8'hC7;
        clear_mon();
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) hold_line(b[i], BIT_CLKS);
        hold_line(b[3], 16);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++; $display("FAIL en_mid_frame: busy got %b expected 1", o_busy);
        end
        i_rx_en = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++; $display("FAIL en_drop_busy: busy got %b expected 0", o_busy);
        end
        hold_line(b[3], 15);
        for (int i = 4; i < SIZE_DATA; i++) hold_line(b[i], BIT_CLKS);
        hold_line(1'b1, BIT_CLKS);
        checks++;
        if (got_q.size() !== 0 || err_seen !== 0 || o_rx_byte !== last_good) begin
            failures++;
            $display("FAIL en_drop_discard: got valid=%0d err=%0d byte=%h expected 0 0 %h",
                     got_q.size(), err_seen, o_rx_byte, last_good);
        end
        i_rx_en = 1'b1;
        hold_line(1'b1, BIT_CLKS);
        send_frame(8'h5A, 1'b1);
        hold_line(1'b1, 40);
        v = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (got_q.size() !== 1 || v !== 8'h5A) begin
            failures++; $display("FAIL en_next: got count=%0d byte=%h expected 1 5a", got_q.size(), v);
        end
        last_good = 8'h5A;
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        clear_mon();
        hold_line(1'b0, BIT_CLKS);
        hold_line(1'b1, BIT_CLKS);
        hold_line(1'b0, 16);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rx_byte, o_rx_valid, o_frame_err, o_busy} !== 11'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got byte=%h valid=%b err=%b busy=%b expected all 0",
                     o_rx_byte, o_rx_valid, o_frame_err, o_busy);
        end
        i_rx_data = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        hold_line(1'b1, BIT_CLKS);
        send_frame(8'h99, 1'b1);
        hold_line(1'b1, 40);
        v = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (got_q.size() !== 1 || v !== 8'h99 || err_seen !== 0) begin
            failures++; $display("FAIL rst_mid_next: got count=%0d byte=%h err=%0d expected 1 99 0", got_q.size(), v, err_seen);
        end
        last_good = 8'h99;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_err;
        logic [7:0] b;
        logic       stop;
        int         gap;
        int         bad;
        clear_mon();
        exp_err = 0;
        for (int n = 0; n < 20; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, 40);
            send_frame(b, stop);
            if (stop) begin
                exp_q.push_back(b);
                last_good = b;
                hold_line(1'b1, gap);
            end else begin
                exp_err++;
                hold_line(1'b0, $urandom_range(10, 60));
                hold_line(1'b1, 8 + gap);
            end
        end
        hold_line(1'b1, 40);
        checks++;
        if (got_q.size() !== exp_q.size() || err_seen !== exp_err || both_seen !== 0) begin
            failures++;
            $display("FAIL rand_counts: got valid=%0d err=%0d both=%0d expected valid=%0d err=%0d both=0",
                     got_q.size(), err_seen, both_seen, exp_q.size(), exp_err);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("FAIL rand_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL rand_bytes: %0d bytes differ, expected 0", bad);
        end
        checks++;
        if (o_rx_byte !== last_good) begin
            failures++; $display("FAIL rand_last_byte: got %h expected %h", o_rx_byte, last_good);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        logic [7:0] v;
        clear_mon();
        hold_line(1'b0, BIT_CLKS);
        hold_line(1'b0, 2 * BIT_CLKS);
        // One-tick high pulse around the centre of data bit 2.
        hold_line(1'b0, 17);
        hold_line(1'b1, 2);
        hold_line(1'b0, 13);
        hold_line(1'b0, 5 * BIT_CLKS);
        hold_line(1'b1, BIT_CLKS);
        hold_line(1'b1, 40);
        v = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        checks++;
        if (got_q.size() !== 1 || v !== 8'h00) begin
            failures++; $display("FAIL majority_glitch: got count=%0d byte=%h expected 1 00", got_q.size(), v);
        end
        last_good = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_rx_en_drop();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
